// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle fetch/execute sequencer owning the PC for the 9-bit core
module fetch_sequencer #(
    parameter int PC_WIDTH    = 10,
    parameter int INSTR_WIDTH = 9,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    start_addr,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_valid,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instr,
    input  logic                   jump,
    input  logic [7:0]             imm,
    input  logic                   branch_taken,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic                   dmem_ready,
    input  logic                   done,
    output logic                   commit,
    output logic                   halted,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [CNT_WIDTH-1:0]   cycle_count,
    output logic [CNT_WIDTH-1:0]   instr_count
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_EXEC     = 3'd2;
    localparam logic [2:0] S_MEM_WAIT = 3'd3;
    localparam logic [2:0] S_HALT     = 3'd4;

    localparam logic [PC_WIDTH-1:0]  PC_ONE  = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0]  PC_TWO  = PC_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [2:0]          state;
    logic [2:0]          state_next;
    logic [PC_WIDTH-1:0] pc_next;
    logic [PC_WIDTH-1:0] imm_ext;
    logic signed [7:0]   imm_signed;
    logic                load_instr;
    logic                clear_counts;
    logic                active;

    // Signed size cast sign-extends the jump offset; the add then wraps modulo 2^PC_WIDTH.
    assign imm_signed = imm;
    assign imm_ext    = PC_WIDTH'(imm_signed);

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign halted    = (state == S_HALT);
    assign active    = (state == S_FETCH) || (state == S_EXEC) || (state == S_MEM_WAIT);

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        commit       = 1'b0;
        load_instr   = 1'b0;
        clear_counts = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_next   = S_FETCH;
                    pc_next      = start_addr;
                    clear_counts = 1'b1;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    load_instr = 1'b1;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (done) begin
                    commit     = 1'b1;
                    state_next = S_HALT;
                end else if ((mem_read || mem_write) && !dmem_ready) begin
                    state_next = S_MEM_WAIT;
                end else begin
                    commit     = 1'b1;
                    state_next = S_FETCH;
                    if (jump)
                        pc_next = pc + imm_ext;
                    else if (branch_taken)
                        pc_next = pc + PC_TWO;
                    else
                        pc_next = pc + PC_ONE;
                end
            end
            S_MEM_WAIT: begin
                // Only loads/stores reach here, so control flow is always sequential.
                if (dmem_ready) begin
                    commit     = 1'b1;
                    pc_next    = pc + PC_ONE;
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            instr <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (load_instr)
                instr <= imem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else if (clear_counts) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            if (active && (cycle_count != CNT_MAX))
                cycle_count <= cycle_count + CNT_ONE;
            if (commit && (instr_count != CNT_MAX))
                instr_count <= instr_count + CNT_ONE;
        end
    end

endmodule
